tt_probe: RTL and testbench
===========================

Name: tt_probe

Overview:
- Sequential characteriser for 3-input single-output logic blocks in the wolfram function set; the inverse of a truth-table module.
- Drives in1/in2/in3 through all 8 rows, waits a settle interval per row, samples `out`, and assembles the 8-bit function code (e.g. 0x1B).
- Sits in the bench/characterisation harness beside any mXX module. All ports connect by name.

Parameters:
- SETTLE_CYCLES, 4, cycles each row is held before sampling; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- busy  output  1  high from the cycle after start is accepted until the cycle DONE is entered
- done  output  1  one-cycle pulse; code/err valid from this cycle onward
- code  output  8  recovered function code; holds until the next done
- err  output  1  glitch flag, valid with done (see Optional Feature)
- in1  output  1  row MSB driven to the block under test
- in2  output  1  row middle bit
- in3  output  1  row LSB
- out  input  1  response of the block under test

Behaviour:
- Reset (synchronous, active-high, clk rising edge) gives:
  - state = IDLE, row = 0, counter = 0
  - in1/in2/in3 = 0, busy = 0, done = 0, code = 8'h00, err = 0, shadow register = 0
- Row mapping: {in1,in2,in3} = row[2:0].
  - Sampled `out` is written to shadow bit (7 - row). Row 000 maps to code bit 7; row 111 maps to code bit 0.
  - Example: outputs 0,0,0,1,1,0,1,1 for rows 0..7 give 8'h1B.
- States:
  - IDLE
    - Drives 000.
    - When start = 1: go to SETTLE, row = 0, counter = 0, shadow cleared, busy = 1.
  - SETTLE
    - Drives row; counter increments each cycle.
    - When counter == SETTLE_CYCLES-1: go to SAMPLE.
  - SAMPLE
    - Captures `out` into shadow[7-row].
    - If row == 7: go to DONE (or CHECK with the feature enabled).
    - Otherwise (or CHECK with the feature enabled): row++, counter = 0, go to SETTLE.
  - DONE
    - code <= shadow, done = 1 for exactly one cycle, busy = 0.
    - Next state is IDLE; drives return to 000.
- Latency:
  - Each row costs SETTLE_CYCLES + 1 cycles.
  - done asserts 8*(SETTLE_CYCLES+1) + 1 cycles after the start edge. This is 41 cycles at the default.
- start while busy, and start in the DONE cycle, are ignored with no queuing.
- start in the cycle after DONE (state IDLE) is accepted normally.
- Reset mid-sweep aborts with no done pulse. code reverts to 00 and err to 0.
- `out` is sampled on exactly one edge per row. Any change in the settle window is invisible, except under the feature.

Optional Feature:
- Macro: TT_PROBE_GLITCH_CHK_EN
- With the macro:
  - A CHECK state follows every SAMPLE and re-samples `out` one cycle later.
  - A mismatch sets the sticky shadow_err; err <= shadow_err at DONE.
  - Each row costs SETTLE_CYCLES + 2 cycles, so done asserts at 8*(SETTLE_CYCLES+2) + 1 cycles. This is 49 cycles at the default.
  - code always takes the SAMPLE value.
- Without the macro:
  - No CHECK state.
  - err is tied to 0.
  - Timing is as in Behaviour.

Decomposition:
- Package tt_probe_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, CHECK, DONE)
  - localparam ROWS = 8 and CODE_W = 8
  - function row_bit(row) returning 7 - row
- One sub-module is natural: tt_settle_timer.
  - Load/count/expire counter parameterised by SETTLE_CYCLES and CNT_W.
  - Instantiated once.

Test Plan:
- Connect a behavioural 0x1B block and pulse start: done at cycle 41, code = 8'h1B, err = 0. Drive sequence 000..111, each row held 5 cycles.
- Constant-0 DUT, then XOR3 DUT, back to back with start the cycle after done: code = 8'h00, then 8'h69. Second done 41 cycles after the second start.
- Pulse start again at cycles 3 and 40 of a sweep: no restart. Single done at cycle 41; busy deasserts only in the DONE cycle.
- Assert rst during row 5: next cycle all outputs are at reset values and no done appears. A new start yields the correct code.
- SETTLE_CYCLES = 1 with an AND3 DUT: each row held 2 cycles, done at cycle 17, code = 8'h01.
- TT_PROBE_GLITCH_CHK_EN, with the DUT output inverting one cycle after sampling on row 3 only: done at cycle 49, err = 1. code equals the SAMPLE-time values.

Source files
------------

// File: rtl/tt_probe_pkg.sv
// tt_probe_pkg: shared types and constants for the truth-table probe.
//   state_t  - sweep FSM states
//   ROWS     - number of input combinations of a 3-input block
//   CODE_W   - width of the recovered function code
//   row_bit  - code bit that a given row lands in (row 000 -> bit 7)
package tt_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CHECK,
        DONE
    } state_t;

    localparam int ROWS   = 8;
    localparam int CODE_W = 8;

    function automatic logic [2:0] row_bit(input logic [2:0] row);
        return 3'(ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: settle-window timer for the probe.
//   clk, rst  - clock, synchronous active-high reset
//   load      - restart the window (takes effect on the next edge)
//   expired   - high in the last cycle of the window
// Down-counter loaded with SETTLE_CYCLES-1; the window ends when it reaches
// zero, so a row is held for exactly SETTLE_CYCLES cycles after a load.
module tt_settle_timer
    import tt_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/tt_probe.sv
// tt_probe: sequential characteriser for 3-input, 1-output logic blocks.
// Walks {in1,in2,in3} through rows 000..111, holds each row for
// SETTLE_CYCLES, samples `out` and assembles the 8-bit function code
// (row 000 -> code bit 7, row 111 -> code bit 0).
//   clk, rst        - clock, synchronous active-high reset
//   start           - sweep request, honoured only when idle
//   busy            - sweep in progress (drops in the DONE cycle)
//   done            - one-cycle pulse; code/err valid from this cycle on
//   code, err       - recovered function code, glitch flag
//   in1, in2, in3   - row drive to the block under test (in1 = MSB)
//   out             - response of the block under test
// Build option: TT_PROBE_GLITCH_CHK_EN adds a CHECK state that re-samples
// `out` one cycle after each SAMPLE and raises err on any disagreement.
//
// state  | meaning
// IDLE   | drives 000, waits for start
// SETTLE | drives row, waits for the settle timer
// SAMPLE | captures out into the code bit for this row
// CHECK  | re-samples out and flags a mismatch (glitch check build only)
// DONE   | publishes code/err, pulses done
module tt_probe
    import tt_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] code,
    output logic              err,
    output logic              in1,
    output logic              in2,
    output logic              in3,
    input  logic              out
);

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t            state, state_nxt;
    logic [2:0]        row, row_nxt;
    logic [CODE_W-1:0] shadow, shadow_nxt;
    logic [CODE_W-1:0] code_r;
    logic              tmr_load, tmr_exp;
    logic              sweeping;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expired(tmr_exp)
    );

`ifdef TT_PROBE_GLITCH_CHK_EN
    logic shadow_err, shadow_err_nxt, err_r;
`endif

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        shadow_nxt = shadow;
        tmr_load   = 1'b0;
`ifdef TT_PROBE_GLITCH_CHK_EN
        shadow_err_nxt = shadow_err;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SETTLE;
                    row_nxt    = '0;
                    shadow_nxt = '0;
                    tmr_load   = 1'b1;
`ifdef TT_PROBE_GLITCH_CHK_EN
                    shadow_err_nxt = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (tmr_exp) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_nxt[row_bit(row)] = out;
`ifdef TT_PROBE_GLITCH_CHK_EN
                state_nxt = CHECK;
`else
                if (row == LAST_ROW) begin
                    state_nxt = DONE;
                end else begin
                    row_nxt   = row + 3'd1;
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
`endif
            end
`ifdef TT_PROBE_GLITCH_CHK_EN
            CHECK: begin
                // code keeps the SAMPLE value; only the flag sees the re-sample
                if (out != shadow[row_bit(row)]) begin
                    shadow_err_nxt = 1'b1;
                end
                if (row == LAST_ROW) begin
                    state_nxt = DONE;
                end else begin
                    row_nxt   = row + 3'd1;
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // code/err are loaded on the edge into DONE so they are already valid
    // in the cycle that done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            shadow <= '0;
            code_r <= '0;
`ifdef TT_PROBE_GLITCH_CHK_EN
            shadow_err <= 1'b0;
            err_r      <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            shadow <= shadow_nxt;
`ifdef TT_PROBE_GLITCH_CHK_EN
            shadow_err <= shadow_err_nxt;
`endif
            if (state_nxt == DONE) begin
                code_r <= shadow_nxt;
`ifdef TT_PROBE_GLITCH_CHK_EN
                err_r  <= shadow_err_nxt;
`endif
            end
        end
    end

    assign sweeping = (state == SETTLE) || (state == SAMPLE) || (state == CHECK);

    assign busy            = sweeping;
    assign done            = (state == DONE);
    assign code            = code_r;
    assign {in1, in2, in3} = sweeping ? row : 3'b000;

`ifdef TT_PROBE_GLITCH_CHK_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_probe.sv
// tb_tt_probe: self-checking bench for tt_probe. Two probes (default settle
// and settle = 1) each drive a behavioural 3-input block; sweeps are checked
// for latency, drive sequence, busy window, code and err.
// Honours TT_PROBE_GLITCH_CHK_EN for the expected timing and err results.
module tb_tt_probe;

`ifdef TT_PROBE_GLITCH_CHK_EN
    localparam int   EXTRA = 2;
    localparam logic GCHK  = 1'b1;
`else
    localparam int   EXTRA = 1;
    localparam logic GCHK  = 1'b0;
`endif
    localparam int S0   = 4;
    localparam int S1   = 1;
    localparam int LAT0 = 8 * (S0 + EXTRA) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic       busy0, done0, err0, i10, i20, i30, out0;
    logic       busy1, done1, err1, i11, i21, i31, out1;
    logic [7:0] code0, code1;
    logic [2:0] drv0, drv1;

    int         kind0 = 1, kind1 = 1, gmode0 = 0;
    logic [7:0] map0 = '0, map1 = '0;

    int n_chk = 0;
    int n_fail = 0;

    tt_probe #(.SETTLE_CYCLES(S0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .code(code0), .err(err0), .in1(i10), .in2(i20), .in3(i30), .out(out0)
    );

    tt_probe #(.SETTLE_CYCLES(S1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .code(code1), .err(err1), .in1(i11), .in2(i21), .in3(i31), .out(out1)
    );

    assign drv0 = {i10, i20, i30};
    assign drv1 = {i11, i21, i31};

    // Behavioural blocks under test: 0 = the 0x1B function, 1 = constant 0,
    // 2 = XOR3, 3 = AND3, otherwise a row-indexed table (bit r = out for row r).
    function automatic logic blk(input int kind, input logic [2:0] r, input logic [7:0] map);
        logic a, b, c;
        {a, b, c} = r;
        case (kind)
            0:       return (a & ~c) | (a & b) | (~a & b & c);
            1:       return 1'b0;
            2:       return a ^ b ^ c;
            3:       return a & b & c;
            default: return map[r];
        endcase
    endfunction

    // Cycle index within the current held row of probe 0, used to place glitches.
    logic [2:0] prev_drv0 = 3'd0;
    int         prev_idx0 = 0;
    int         idx0;
    logic       glitch0;
    always_comb idx0 = (drv0 == prev_drv0) ? prev_idx0 + 1 : 0;
    always @(posedge clk) begin
        prev_drv0 <= drv0;
        prev_idx0 <= idx0;
    end
    always_comb glitch0 = (drv0 == 3'd3) &&
                          ((gmode0 == 1 && idx0 == 1) || (gmode0 == 2 && idx0 == S0 + 1));
    always_comb out0 = blk(kind0, drv0, map0) ^ glitch0;
    always_comb out1 = blk(kind1, drv1, map1);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Called #1 after an edge with the selected probe idle. Extra start pulses
    // are driven during cycles x1/x2 (cycle 1 = first cycle after acceptance).
    // Returns #1 into the cycle after done.
    task automatic sweep(input int sel, input int kind, input logic [7:0] map, input int gmode,
                         input int x1, input int x2, input logic [7:0] exp_code,
                         input logic exp_err, input string tag);
        int         s, per, lat, n, done_at, seq_bad, busy_bad;
        logic [2:0] d;
        logic       b, dn, e, busy_at_done;
        logic [7:0] c;
        s   = (sel == 0) ? S0 : S1;
        per = s + EXTRA;
        lat = 8 * per + 1;
        if (sel == 0) begin kind0 = kind; map0 = map; gmode0 = gmode; end
        else          begin kind1 = kind; map1 = map; end
        done_at = 0; seq_bad = 0; busy_bad = 0; busy_at_done = 1'b1; c = '0; e = 1'b0;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (n = 1; n <= lat + 20; n++) begin
            d  = (sel == 0) ? drv0  : drv1;
            b  = (sel == 0) ? busy0 : busy1;
            dn = (sel == 0) ? done0 : done1;
            if (dn) begin
                done_at      = n;
                busy_at_done = b;
                c            = (sel == 0) ? code0 : code1;
                e            = (sel == 0) ? err0  : err1;
                if (d != 3'd0) seq_bad++;
            end else begin
                if (!b) busy_bad++;
                if (n < lat && d != 3'((n - 1) / per)) seq_bad++;
            end
            set_start(sel, (n == x1) || (n == x2));
            @(posedge clk); #1;
            set_start(sel, 1'b0);
            if (dn) break;
        end
        chk({tag, ":latency"},      32'(done_at),      32'(lat));
        chk({tag, ":code"},         {24'd0, c},        {24'd0, exp_code});
        chk({tag, ":err"},          {31'd0, e},        {31'd0, exp_err});
        chk({tag, ":drive_seq"},    32'(seq_bad),      32'd0);
        chk({tag, ":busy_window"},  32'(busy_bad),     32'd0);
        chk({tag, ":busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
        chk({tag, ":idle_after"},
            {30'd0, (sel == 0) ? busy0 : busy1, (sel == 0) ? done0 : done1}, 32'd0);
        chk({tag, ":code_hold"}, {24'd0, (sel == 0) ? code0 : code1}, {24'd0, exp_code});
    endtask

    typedef struct {
        int         sel;
        int         kind;
        int         gmode;
        int         x1;
        int         x2;
        logic [7:0] exp_code;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         wait_cyc, dones;
        logic [7:0] rmap, rexp;

        vecs[0] = '{0, 0, 0, 0, 0,    8'h1B, 1'b0};   // 0x1B block
        vecs[1] = '{0, 1, 0, 0, 0,    8'h00, 1'b0};   // constant 0
        vecs[2] = '{0, 2, 0, 0, 0,    8'h69, 1'b0};   // XOR3, started right after done
        vecs[3] = '{0, 0, 0, 3, 40,   8'h1B, 1'b0};   // start pulses mid-sweep
        vecs[4] = '{0, 2, 1, 0, LAT0, 8'h69, 1'b0};   // settle-window glitch, start in DONE
        vecs[5] = '{1, 3, 0, 0, 0,    8'h01, 1'b0};   // AND3 with settle = 1
        vecs[6] = '{0, 0, 2, 0, 0,    8'h1B, GCHK};   // inversion right after sampling row 3
        vecs[7] = '{1, 2, 0, 5, 0,    8'h69, 1'b0};   // XOR3, settle = 1, spurious start

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:code0",    {24'd0, code0}, 32'd0);
        chk("reset:busy_done", {28'd0, busy0, done0, busy1, done1}, 32'd0);
        chk("reset:drive0",   {29'd0, drv0}, 32'd0);
        chk("reset:err",      {30'd0, err0, err1}, 32'd0);
        chk("reset:code1",    {24'd0, code1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            sweep(vecs[i].sel, vecs[i].kind, 8'h00, vecs[i].gmode, vecs[i].x1, vecs[i].x2,
                  vecs[i].exp_code, vecs[i].exp_err, $sformatf("vec%0d", i));
        end
        gmode0 = 0;

        // Reset in the middle of row 5: abort, no done, outputs back to reset values.
        kind0 = 2;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5 * (S0 + EXTRA) + 1) @(posedge clk);
        #1;
        chk("rst_mid:row5_reached", {29'd0, drv0}, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid:busy_done", {30'd0, busy0, done0}, 32'd0);
        chk("rst_mid:code",      {24'd0, code0}, 32'd0);
        chk("rst_mid:err",       {31'd0, err0}, 32'd0);
        chk("rst_mid:drive",     {29'd0, drv0}, 32'd0);
        dones = 0;
        for (wait_cyc = 0; wait_cyc < 60; wait_cyc++) begin
            if (done0 || busy0) dones++;
            @(posedge clk); #1;
        end
        chk("rst_mid:no_done", 32'(dones), 32'd0);
        sweep(0, 2, 8'h00, 0, 0, 0, 8'h69, 1'b0, "after_rst");

        // Random truth tables; expected code built row by row from the table.
        for (int k = 0; k < 6; k++) begin
            rmap = 8'($urandom);
            for (int r = 0; r < 8; r++) rexp[7 - r] = rmap[r];
            sweep(k % 2, 4, rmap, 0, int'($urandom_range(2, 8)), 0, rexp, 1'b0,
                  $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
